// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, seven-slave memory bus arbiter.
// Decodes MADDR[31:SEL_LSB] to a slave and runs one transaction at a time.
// Masters are picked round-robin. MDATAR and the returned ready/error
// pulse go back to the master that was granted.
module mem_bus_arbiter #(
    parameter int          SEL_LSB  = 28,
    parameter int          RD_LAT   = 1,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        MEN1,
    input  logic        MWEN1,
    input  logic [31:0] MADDR1,
    input  logic [31:0] MDATAW1,
    output logic [31:0] MDATAR1,
    output logic        MRDY1,
    output logic        MERR1,
    input  logic        MEN3,
    input  logic        MWEN3,
    input  logic [31:0] MADDR3,
    input  logic [31:0] MDATAW3,
    output logic [31:0] MDATAR3,
    output logic        MRDY3,
    output logic        MERR3,
    output logic [31:0] SADDR1,  output logic [31:0] SDATAW1,  output logic SWEN1,  input logic [31:0] SDATAR1,
    output logic [31:0] SADDR3,  output logic [31:0] SDATAW3,  output logic SWEN3,  input logic [31:0] SDATAR3,
    output logic [31:0] SADDR5,  output logic [31:0] SDATAW5,  output logic SWEN5,  input logic [31:0] SDATAR5,
    output logic [31:0] SADDR7,  output logic [31:0] SDATAW7,  output logic SWEN7,  input logic [31:0] SDATAR7,
    output logic [31:0] SADDR9,  output logic [31:0] SDATAW9,  output logic SWEN9,  input logic [31:0] SDATAR9,
    output logic [31:0] SADDR11, output logic [31:0] SDATAW11, output logic SWEN11, input logic [31:0] SDATAR11,
    output logic [31:0] SADDR13, output logic [31:0] SDATAW13, output logic SWEN13, input logic [31:0] SDATAR13
);

    // Slave-side address keeps only the offset below the select field
    localparam logic [31:0] LOW_MASK = (32'h1 << SEL_LSB) - 32'h1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

    state_t      r_state, w_next;
    logic        r_last;          // 0: M1 granted last, 1: M3 granted last
    logic        r_mid;           // granted master: 0 = M1, 1 = M3
    logic        r_we;
    logic [2:0]  r_slv;
    logic [2:0]  r_cnt;
    logic [31:0] r_saddr  [7];
    logic [31:0] r_sdataw [7];
    logic [31:0] r_mdatar [2];

    logic        w_any, w_gnt3, w_we, w_valid;
    logic [31:0] w_addr, w_wdata, w_sel;
    logic [2:0]  w_slv;
    logic [1:0]  w_mrdy, w_merr;
    logic [6:0]  w_swen;
    logic [31:0] w_sdatar [7];

    assign w_sdatar[0] = SDATAR1;
    assign w_sdatar[1] = SDATAR3;
    assign w_sdatar[2] = SDATAR5;
    assign w_sdatar[3] = SDATAR7;
    assign w_sdatar[4] = SDATAR9;
    assign w_sdatar[5] = SDATAR11;
    assign w_sdatar[6] = SDATAR13;

    // Round-robin pick and address decode of the master that would win now
    always_comb begin
        w_any   = MEN1 | MEN3;
        w_gnt3  = MEN3 & (~MEN1 | ~r_last);
        w_we    = w_gnt3 ? MWEN3   : MWEN1;
        w_addr  = w_gnt3 ? MADDR3  : MADDR1;
        w_wdata = w_gnt3 ? MDATAW3 : MDATAW1;
        w_sel   = w_addr >> SEL_LSB;
        w_valid = (w_sel < 32'd7);
        w_slv   = w_sel[2:0];
    end

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state and Moore outputs (ready/error pulses, write strobes)
    always_comb begin
        w_next = r_state;
        w_mrdy = 2'b00;
        w_merr = 2'b00;
        w_swen = 7'b0;
        case (r_state)
            IDLE:  if (w_any) w_next = w_valid ? ISSUE : ERR;
            ISSUE: begin
                if (r_we) w_swen = 7'b1 << r_slv;
                w_next = r_we ? RESP : WAIT;
            end
            WAIT:  if (r_cnt == 3'd1) w_next = RESP;
            RESP:  begin
                w_mrdy[r_mid] = 1'b1;
                w_next        = IDLE;
            end
            ERR:   begin
                w_mrdy[r_mid] = 1'b1;
                w_merr[r_mid] = 1'b1;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Grant latching, slave bus registers, latency counter and read return
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_last <= 1'b1;
            r_mid  <= 1'b0;
            r_we   <= 1'b0;
            r_slv  <= 3'd0;
            r_cnt  <= 3'd0;
            for (int k = 0; k < 7; k++) begin
                r_saddr[k]  <= 32'h0;
                r_sdataw[k] <= 32'h0;
            end
            r_mdatar[0] <= 32'h0;
            r_mdatar[1] <= 32'h0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_mid  <= w_gnt3;
                    r_last <= w_gnt3;
                    r_we   <= w_we;
                    r_slv  <= w_slv;
                    if (w_valid) begin
                        // Slave bus is loaded at grant so it is visible in ISSUE
                        r_saddr[w_slv]  <= w_addr & LOW_MASK;
                        r_sdataw[w_slv] <= w_wdata;
                    end else if (!w_we) begin
                        r_mdatar[w_gnt3] <= ERR_DATA;
                    end
                end
                ISSUE: r_cnt <= 3'(RD_LAT);
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) r_mdatar[r_mid] <= w_sdatar[r_slv];
                end
                default: ;
            endcase
        end
    end

    assign MDATAR1 = r_mdatar[0];
    assign MDATAR3 = r_mdatar[1];
    assign MRDY1   = w_mrdy[0];
    assign MRDY3   = w_mrdy[1];
    assign MERR1   = w_merr[0];
    assign MERR3   = w_merr[1];

    assign SADDR1  = r_saddr[0];  assign SDATAW1  = r_sdataw[0];  assign SWEN1  = w_swen[0];
    assign SADDR3  = r_saddr[1];  assign SDATAW3  = r_sdataw[1];  assign SWEN3  = w_swen[1];
    assign SADDR5  = r_saddr[2];  assign SDATAW5  = r_sdataw[2];  assign SWEN5  = w_swen[2];
    assign SADDR7  = r_saddr[3];  assign SDATAW7  = r_sdataw[3];  assign SWEN7  = w_swen[3];
    assign SADDR9  = r_saddr[4];  assign SDATAW9  = r_sdataw[4];  assign SWEN9  = w_swen[4];
    assign SADDR11 = r_saddr[5];  assign SDATAW11 = r_sdataw[5];  assign SWEN11 = w_swen[5];
    assign SADDR13 = r_saddr[6];  assign SDATAW13 = r_sdataw[6];  assign SWEN13 = w_swen[6];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized and directed checks of mem_bus_arbiter
// against a transaction-level model (latency table, round-robin order,
// reference memory image per slave).
module tb_mem_bus_arbiter;

    localparam int          RD_LAT   = 1;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // ---------------- DUT (RD_LAT = 1) ----------------
    logic        men1, mwen1, men3, mwen3;
    logic [31:0] maddr1, mdataw1, maddr3, mdataw3;
    logic [31:0] mdatar1, mdatar3;
    logic        mrdy1, merr1, mrdy3, merr3;
    logic [31:0] saddr [7];
    logic [31:0] sdataw [7];
    logic [31:0] sdatar [7];
    logic [6:0]  swen;

    mem_bus_arbiter #(.SEL_LSB(28), .RD_LAT(RD_LAT), .ERR_DATA(ERR_DATA)) dut (
        .CLK(clk), .RSTN(rstn),
        .MEN1(men1), .MWEN1(mwen1), .MADDR1(maddr1), .MDATAW1(mdataw1),
        .MDATAR1(mdatar1), .MRDY1(mrdy1), .MERR1(merr1),
        .MEN3(men3), .MWEN3(mwen3), .MADDR3(maddr3), .MDATAW3(mdataw3),
        .MDATAR3(mdatar3), .MRDY3(mrdy3), .MERR3(merr3),
        .SADDR1(saddr[0]),  .SDATAW1(sdataw[0]),  .SWEN1(swen[0]),  .SDATAR1(sdatar[0]),
        .SADDR3(saddr[1]),  .SDATAW3(sdataw[1]),  .SWEN3(swen[1]),  .SDATAR3(sdatar[1]),
        .SADDR5(saddr[2]),  .SDATAW5(sdataw[2]),  .SWEN5(swen[2]),  .SDATAR5(sdatar[2]),
        .SADDR7(saddr[3]),  .SDATAW7(sdataw[3]),  .SWEN7(swen[3]),  .SDATAR7(sdatar[3]),
        .SADDR9(saddr[4]),  .SDATAW9(sdataw[4]),  .SWEN9(swen[4]),  .SDATAR9(sdatar[4]),
        .SADDR11(saddr[5]), .SDATAW11(sdataw[5]), .SWEN11(swen[5]), .SDATAR11(sdatar[5]),
        .SADDR13(saddr[6]), .SDATAW13(sdataw[6]), .SWEN13(swen[6]), .SDATAR13(sdatar[6])
    );

    // ---------------- second DUT (RD_LAT = 4), only M1 used ----------------
    logic        m4_men1, m4_mwen1;
    logic [31:0] m4_maddr1, m4_mdataw1, m4_mdatar1, m4_mdatar3;
    logic        m4_mrdy1, m4_merr1, m4_mrdy3, m4_merr3;
    logic [31:0] saddr4 [7];
    logic [31:0] sdataw4 [7];
    logic [31:0] sdatar4 [7];
    logic [6:0]  swen4;

    mem_bus_arbiter #(.SEL_LSB(28), .RD_LAT(4), .ERR_DATA(ERR_DATA)) dut4 (
        .CLK(clk), .RSTN(rstn),
        .MEN1(m4_men1), .MWEN1(m4_mwen1), .MADDR1(m4_maddr1), .MDATAW1(m4_mdataw1),
        .MDATAR1(m4_mdatar1), .MRDY1(m4_mrdy1), .MERR1(m4_merr1),
        .MEN3(1'b0), .MWEN3(1'b0), .MADDR3(32'h0), .MDATAW3(32'h0),
        .MDATAR3(m4_mdatar3), .MRDY3(m4_mrdy3), .MERR3(m4_merr3),
        .SADDR1(saddr4[0]),  .SDATAW1(sdataw4[0]),  .SWEN1(swen4[0]),  .SDATAR1(sdatar4[0]),
        .SADDR3(saddr4[1]),  .SDATAW3(sdataw4[1]),  .SWEN3(swen4[1]),  .SDATAR3(sdatar4[1]),
        .SADDR5(saddr4[2]),  .SDATAW5(sdataw4[2]),  .SWEN5(swen4[2]),  .SDATAR5(sdatar4[2]),
        .SADDR7(saddr4[3]),  .SDATAW7(sdataw4[3]),  .SWEN7(swen4[3]),  .SDATAR7(sdatar4[3]),
        .SADDR9(saddr4[4]),  .SDATAW9(sdataw4[4]),  .SWEN9(swen4[4]),  .SDATAR9(sdatar4[4]),
        .SADDR11(saddr4[5]), .SDATAW11(sdataw4[5]), .SWEN11(swen4[5]), .SDATAR11(sdatar4[5]),
        .SADDR13(saddr4[6]), .SDATAW13(sdataw4[6]), .SWEN13(swen4[6]), .SDATAR13(sdatar4[6])
    );

    // ---------------- slave memories ----------------
    // 16 words per slave, indexed by address bits [5:2]; written mid-cycle on SWEN
    logic [31:0] smem [7][16];

    initial begin
        for (int k = 0; k < 7; k++)
            for (int w = 0; w < 16; w++)
                smem[k][w] = {8'h51, 8'(k), 8'h00, 8'(w)};
        smem[6][1] = 32'h1234_5678;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 7; k++)
                if (swen[k]) smem[k][saddr[k][5:2]] = sdataw[k];
        end
    end

    for (genvar g = 0; g < 7; g++) begin : g_slv
        assign sdatar[g]  = smem[g][saddr[g][5:2]];
        assign sdatar4[g] = {8'hA4, 8'(g), saddr4[g][15:0]};
    end

    // ---------------- reference model state ----------------
    int          mdl_last;          // master granted last (0 = M1, 1 = M3)
    logic [31:0] exp_mdatar [2];
    logic [31:0] ref_mem [7][16];

    task automatic set_req(input int m, input logic en, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin men1 = en; mwen1 = we; maddr1 = a; mdataw1 = d; end
        else        begin men3 = en; mwen3 = we; maddr3 = a; mdataw3 = d; end
    endtask

    function automatic logic get_mrdy(input int m);
        return (m == 0) ? mrdy1 : mrdy3;
    endfunction
    function automatic logic get_merr(input int m);
        return (m == 0) ? merr1 : merr3;
    endfunction
    function automatic logic [31:0] get_mdatar(input int m);
        return (m == 0) ? mdatar1 : mdatar3;
    endfunction

    // Drives one request from an idle bus and records what the DUT did.
    // Starts and ends on a falling edge inside an IDLE cycle.
    task automatic run_txn(input int m, input logic we, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic err, output logic [31:0] rdat,
                           output int swen_cnt, output logic [6:0] sw_at1,
                           output logic [31:0] sa_at1, output logic [31:0] sd_at1,
                           output logic untouched, output logic other_rdy);
        logic [31:0] sa0 [7];
        logic [31:0] sd0 [7];
        int tgt;
        tgt = int'(a[31:28]);
        for (int k = 0; k < 7; k++) begin sa0[k] = saddr[k]; sd0[k] = sdataw[k]; end
        lat = -1; err = 1'b0; rdat = 32'h0; swen_cnt = 0; sw_at1 = 7'h0;
        sa_at1 = 32'h0; sd_at1 = 32'h0; other_rdy = 1'b0;
        set_req(m, 1'b1, we, a, d);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (swen != 7'h0) swen_cnt++;
            if (n == 1) begin
                sw_at1 = swen;
                if (tgt < 7) begin sa_at1 = saddr[tgt]; sd_at1 = sdataw[tgt]; end
            end
            if (get_mrdy(1 - m)) other_rdy = 1'b1;
            if (get_mrdy(m)) begin
                lat = n; err = get_merr(m); rdat = get_mdatar(m);
                break;
            end
        end
        set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
        untouched = 1'b1;
        for (int k = 0; k < 7; k++)
            if (k != tgt && (saddr[k] !== sa0[k] || sdataw[k] !== sd0[k])) untouched = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] acc;
        #1 rstn = 1'b0;
        #1;
        n_tests++;
        if ({mrdy1, merr1, mrdy3, merr3} !== 4'b0) begin
            n_fail++; $display("FAIL reset_rdy_err: got %b want 0000", {mrdy1, merr1, mrdy3, merr3});
        end
        n_tests++;
        if (mdatar1 !== 32'h0 || mdatar3 !== 32'h0) begin
            n_fail++; $display("FAIL reset_mdatar: got %h/%h want 0/0", mdatar1, mdatar3);
        end
        n_tests++;
        if (swen !== 7'h0) begin
            n_fail++; $display("FAIL reset_swen: got %b want 0", swen);
        end
        acc = 32'h0;
        for (int k = 0; k < 7; k++) acc = acc | saddr[k] | sdataw[k];
        n_tests++;
        if (acc !== 32'h0) begin
            n_fail++; $display("FAIL reset_slave_bus: got %h want 0", acc);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        mdl_last = 1;
        exp_mdatar[0] = 32'h0; exp_mdatar[1] = 32'h0;
    endtask

    task automatic test_write_basic();
        int lat, sc; logic err, un, orr; logic [6:0] sw; logic [31:0] rd, sa, sd;
        run_txn(0, 1'b1, 32'h2000_0010, 32'hA5A5_0001, lat, err, rd, sc, sw, sa, sd, un, orr);
        mdl_last = 0; ref_mem[2][4] = 32'hA5A5_0001;
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL wr_lat: got %0d want 2", lat); end
        n_tests++;
        if (sw !== 7'b0000100 || sc !== 1) begin
            n_fail++; $display("FAIL wr_swen: got %b x%0d want 0000100 x1", sw, sc);
        end
        n_tests++;
        if (sa !== 32'h0000_0010 || sd !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL wr_saddr5: got %h/%h want 00000010/a5a50001", sa, sd);
        end
        n_tests++;
        if (err !== 1'b0 || rd !== exp_mdatar[0] || !un || orr) begin
            n_fail++; $display("FAIL wr_resp: err %b mdatar %h untouched %b other %b", err, rd, un, orr);
        end
    endtask

    task automatic test_read_basic();
        int lat, sc; logic err, un, orr; logic [6:0] sw; logic [31:0] rd, sa, sd;
        run_txn(1, 1'b0, 32'h6000_0004, 32'h0, lat, err, rd, sc, sw, sa, sd, un, orr);
        mdl_last = 1; exp_mdatar[1] = ref_mem[6][1];
        n_tests++;
        if (lat !== 2 + RD_LAT) begin n_fail++; $display("FAIL rd_lat: got %0d want %0d", lat, 2 + RD_LAT); end
        n_tests++;
        if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data: got %h want 12345678", rd); end
        n_tests++;
        if (mdatar1 !== exp_mdatar[0]) begin
            n_fail++; $display("FAIL rd_other_mdatar: got %h want %h", mdatar1, exp_mdatar[0]);
        end
        n_tests++;
        if (err !== 1'b0 || sc !== 0 || sa !== 32'h4 || orr) begin
            n_fail++; $display("FAIL rd_bus: err %b swen_cnt %0d saddr13 %h other %b", err, sc, sa, orr);
        end
    endtask

    task automatic test_decode_err();
        int lat, sc; logic err, un, orr; logic [6:0] sw; logic [31:0] rd, sa, sd;
        run_txn(0, 1'b0, 32'h7000_0000, 32'h0, lat, err, rd, sc, sw, sa, sd, un, orr);
        mdl_last = 0; exp_mdatar[0] = ERR_DATA;
        n_tests++;
        if (lat !== 1 || err !== 1'b1) begin
            n_fail++; $display("FAIL err_resp: lat %0d merr %b want 1/1", lat, err);
        end
        n_tests++;
        if (rd !== ERR_DATA) begin n_fail++; $display("FAIL err_data: got %h want %h", rd, ERR_DATA); end
        n_tests++;
        if (sc !== 0 || !un) begin
            n_fail++; $display("FAIL err_no_slave: swen_cnt %0d untouched %b want 0/1", sc, un);
        end
    endtask

    // Both masters hold write requests; grants must alternate from the model pointer
    task automatic test_back_to_back(input int npulse);
        logic [31:0] ca [2];
        logic [31:0] cd [2];
        int pulses, prev_t, exp_m, obs;
        for (int m = 0; m < 2; m++) begin
            ca[m] = {4'($urandom_range(0, 6)), 22'($urandom), 4'($urandom_range(0, 15)), 2'b00};
            cd[m] = $urandom;
            set_req(m, 1'b1, 1'b1, ca[m], cd[m]);
        end
        pulses = 0; prev_t = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (mrdy1 && mrdy3) begin
                n_tests++; n_fail++; $display("FAIL b2b_both_rdy: at cycle %0d", n);
            end
            if (mrdy1 || mrdy3) begin
                obs   = mrdy3 ? 1 : 0;
                exp_m = 1 - mdl_last;
                n_tests++;
                if (obs !== exp_m) begin
                    n_fail++; $display("FAIL b2b_grant[%0d]: got M%0d want M%0d", pulses, 2*obs+1, 2*exp_m+1);
                end
                n_tests++;
                if (n !== prev_t + 3) begin
                    n_fail++; $display("FAIL b2b_time[%0d]: got %0d want %0d", pulses, n, prev_t + 3);
                end
                ref_mem[ca[exp_m][31:28]][ca[exp_m][5:2]] = cd[exp_m];
                mdl_last = exp_m;
                prev_t   = n;
                pulses++;
                if (pulses == npulse) begin
                    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
                    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
                    break;
                end
                ca[exp_m] = {4'($urandom_range(0, 6)), 22'($urandom), 4'($urandom_range(0, 15)), 2'b00};
                cd[exp_m] = $urandom;
                set_req(exp_m, 1'b1, 1'b1, ca[exp_m], cd[exp_m]);
            end
        end
        n_tests++;
        if (pulses !== npulse) begin
            n_fail++; $display("FAIL b2b_count: got %0d want %0d", pulses, npulse);
            set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
            set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_random(input int iters);
        int lat, sc, m, sel, w, exp_lat; logic we, err, un, orr, valid;
        logic [6:0] sw; logic [31:0] rd, sa, sd, a, d, other;
        for (int i = 0; i < iters; i++) begin
            m = $urandom_range(0, 1); we = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9); w = $urandom_range(0, 15); d = $urandom;
            a = {sel[3:0], 22'($urandom), w[3:0], 2'b00};
            valid   = (sel < 7);
            exp_lat = !valid ? 1 : (we ? 2 : 2 + RD_LAT);
            other   = exp_mdatar[1 - m];
            run_txn(m, we, a, d, lat, err, rd, sc, sw, sa, sd, un, orr);
            mdl_last = m;
            if (!valid && !we)     exp_mdatar[m] = ERR_DATA;
            else if (valid && !we) exp_mdatar[m] = ref_mem[sel][w];
            if (valid && we)       ref_mem[sel][w] = d;
            n_tests++;
            if (lat !== exp_lat || err !== !valid) begin
                n_fail++; $display("FAIL rnd_resp[%0d]: lat %0d merr %b want %0d/%b", i, lat, err, exp_lat, !valid);
            end
            n_tests++;
            if (rd !== exp_mdatar[m]) begin
                n_fail++; $display("FAIL rnd_mdatar[%0d]: got %h want %h", i, rd, exp_mdatar[m]);
            end
            n_tests++;
            if (sc !== ((valid && we) ? 1 : 0) || !un || orr) begin
                n_fail++; $display("FAIL rnd_bus[%0d]: swen_cnt %0d untouched %b other %b", i, sc, un, orr);
            end
            if (valid) begin
                n_tests++;
                if (sw !== (we ? 7'(1 << sel) : 7'h0) || sa !== (a & 32'h0FFF_FFFF) || sd !== d) begin
                    n_fail++; $display("FAIL rnd_issue[%0d]: swen %b saddr %h sdataw %h want %b %h %h",
                                       i, sw, sa, sd, (we ? 7'(1 << sel) : 7'h0), a & 32'h0FFF_FFFF, d);
                end
            end
            n_tests++;
            if (get_mdatar(1 - m) !== other) begin
                n_fail++; $display("FAIL rnd_other[%0d]: got %h want %h", i, get_mdatar(1 - m), other);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] acc;
        int rdy_seen;
        set_req(1, 1'b1, 1'b0, 32'h2000_0008, 32'h0);
        @(posedge clk); @(negedge clk);   // ISSUE
        @(posedge clk); @(negedge clk);   // WAIT
        rstn = 1'b0;
        #1;
        acc = mdatar1 | mdatar3;
        for (int k = 0; k < 7; k++) acc = acc | saddr[k] | sdataw[k];
        n_tests++;
        if (acc !== 32'h0 || swen !== 7'h0 || {mrdy1, mrdy3, merr1, merr3} !== 4'b0) begin
            n_fail++; $display("FAIL rst_async: data or %h swen %b rdy/err %b want all 0",
                               acc, swen, {mrdy1, mrdy3, merr1, merr3});
        end
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rdy_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (mrdy3 || swen != 7'h0) rdy_seen++;
        end
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mrdy3 || swen != 7'h0) rdy_seen++;
        end
        n_tests++;
        if (rdy_seen !== 0) begin n_fail++; $display("FAIL rst_abort: got %0d pulses want 0", rdy_seen); end
        mdl_last = 1;
        exp_mdatar[0] = 32'h0; exp_mdatar[1] = 32'h0;
        n_tests++;
        if (mdl_last !== 1 || mdatar3 !== exp_mdatar[1]) begin
            n_fail++; $display("FAIL rst_mdatar3: got %h want %h", mdatar3, exp_mdatar[1]);
        end
        test_back_to_back(2);
    endtask

    task automatic test_rdlat4();
        int lat, stable, bad;
        logic err;
        logic [31:0] rd, acc;
        m4_mwen1 = 1'b0; m4_mdataw1 = 32'h0; m4_maddr1 = 32'h0000_0040;
        m4_men1  = 1'b1;
        lat = -1; stable = 0; bad = 0; err = 1'b0; rd = 32'h0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (n <= 5 && saddr4[0] === 32'h0000_0040) stable++;
            if (swen4 != 7'h0 || m4_mrdy3 || m4_merr3) bad++;
            if (m4_mrdy1) begin lat = n; err = m4_merr1; rd = m4_mdatar1; break; end
        end
        m4_men1 = 1'b0;
        acc = m4_mdatar3 | sdataw4[0];
        for (int k = 1; k < 7; k++) acc = acc | saddr4[k] | sdataw4[k];
        n_tests++;
        if (lat !== 6) begin n_fail++; $display("FAIL lat4_mrdy: got %0d want 6", lat); end
        n_tests++;
        if (stable !== 5) begin n_fail++; $display("FAIL lat4_saddr: stable %0d want 5", stable); end
        n_tests++;
        if (rd !== 32'hA400_0040 || err !== 1'b0) begin
            n_fail++; $display("FAIL lat4_data: got %h merr %b want a4000040/0", rd, err);
        end
        n_tests++;
        if (bad !== 0 || acc !== 32'h0) begin
            n_fail++; $display("FAIL lat4_quiet: bad %0d other-bus %h want 0/0", bad, acc);
        end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        men1 = 1'b0; mwen1 = 1'b0; maddr1 = 32'h0; mdataw1 = 32'h0;
        men3 = 1'b0; mwen3 = 1'b0; maddr3 = 32'h0; mdataw3 = 32'h0;
        m4_men1 = 1'b0; m4_mwen1 = 1'b0; m4_maddr1 = 32'h0; m4_mdataw1 = 32'h0;
        for (int k = 0; k < 7; k++)
            for (int w = 0; w < 16; w++)
                ref_mem[k][w] = {8'h51, 8'(k), 8'h00, 8'(w)};
        ref_mem[6][1] = 32'h1234_5678;
        mdl_last = 1;
        exp_mdatar[0] = 32'h0; exp_mdatar[1] = 32'h0;

        test_reset();
        test_write_basic();
        test_read_basic();
        test_decode_err();
        test_back_to_back(4);
        test_random(60);
        test_reset_mid_wait();
        test_random(20);
        test_rdlat4();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the two memory masters (ports 1 and 3) onto the seven shared slave ports (1, 3, 5, 7, 9, 11, 13) between the router chiplet and the memory chiplet.
- Address-decodes each request, sequences exactly one transaction at a time on the selected slave, and returns read data plus a one-cycle ready/error response to the requesting master.
- Round-robin fairness between masters.

Parameters:
- SEL_LSB, 28: MADDR[31:SEL_LSB] is the slave-select field. Values 0..6 map to slaves 1,3,5,7,9,11,13; any other value is a decode error.
- RD_LAT, 1: slave read latency in cycles, from SADDR driven to SDATAR valid. Legal range 1..7.
- ERR_DATA, 32'hDEAD_BEEF: value returned on MDATAR for a decode-error read.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- MEN1, MEN3  in  1  master request, held until MRDY.
- MWEN1, MWEN3  in  1  1 = write, 0 = read; stable while MEN is high.
- MADDR1, MADDR3  in  32  byte address; stable while MEN is high.
- MDATAW1, MDATAW3  in  32  write data; stable while MEN is high.
- MDATAR1, MDATAR3  out  32  read data, valid while MRDY is high, then held.
- MRDY1, MRDY3  out  1  one-cycle completion pulse.
- MERR1, MERR3  out  1  decode error, coincident with MRDY.
- SADDR{1,3,5,7,9,11,13}  out  32  slave address, with the select field zeroed.
- SDATAW{1,3,...,13}  out  32  slave write data.
- SWEN{1,3,...,13}  out  1  slave write strobe, one cycle per write.
- SDATAR{1,3,...,13}  in  32  slave read data.

Behaviour:
- Reset (asynchronous on RSTN low):
  - FSM goes to IDLE.
  - All MRDY, MERR and SWEN are 0.
  - All MDATAR, SADDR and SDATAW are 0.
  - Round-robin pointer is set to "last = M3", so M1 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - Samples MEN1 and MEN3.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the master not granted last.
  - On grant, latch master id, we, addr, wdata and decoded slave index; update the pointer.
  - Valid decode goes to ISSUE; invalid decode goes to ERR.
- ISSUE (one cycle):
  - Selected slave: SADDR = {select bits 0, addr[SEL_LSB-1:0]}, SDATAW = wdata, SWEN = we.
  - Write goes to RESP. Read goes to WAIT and loads the counter with RD_LAT.
- WAIT:
  - SADDR is held; SWEN is 0.
  - Counter decrements each cycle.
  - When the counter reaches 1, capture SDATAR of the selected slave and go to RESP.
- RESP (one cycle):
  - Granted master's MRDY = 1, MERR = 0.
  - MDATAR = captured data for reads; unchanged for writes.
  - Next state is IDLE.
- ERR (one cycle):
  - Granted master's MRDY = 1, MERR = 1.
  - MDATAR = ERR_DATA if read, unchanged if write.
  - No slave is touched. Next state is IDLE.
- Master rule: a master samples MRDY at the clock edge and either drops MEN or presents a new request in the next cycle. The arbiter never re-grants during RESP/ERR, so there is no double issue.
- Latency, with a request first seen in IDLE at cycle t:
  - Write: SWEN at t+1, MRDY at t+2.
  - Read: SADDR at t+1, MRDY at t+2+RD_LAT.
  - Error: MRDY at t+1.
- Non-selected slaves: SWEN = 0; SADDR and SDATAW hold their previous values.
- The MDATAR of a non-granted master holds its previous value.
- A master that is not granted keeps waiting. Maximum wait is one full transaction of the other master.
- MEN dropped mid-transaction is ignored; the transaction completes and MRDY still pulses.
- Throughput: at most one transaction per 3 cycles (write) or 3+RD_LAT cycles (read).
- Reset mid-transaction aborts it: no MRDY and no SWEN is issued; outputs return to reset values immediately.

Test Plan:
- M1 write, MADDR1 = 32'h2000_0010, MDATAW1 = 32'hA5A5_0001 → at t+1 SWEN5 = 1, SADDR5 = 32'h0000_0010, SDATAW5 = 32'hA5A5_0001, all other SWEN = 0; MRDY1 = 1 at t+2; MERR1 = 0.
- M3 read, MADDR3 = 32'h6000_0004, slave 13 model returns 32'h1234_5678 with RD_LAT = 1 → MRDY3 at t+3, MDATAR3 = 32'h1234_5678, MDATAR1 unchanged.
- MEN1 and MEN3 asserted together from reset, both writes, held continuously → grant order M1, M3, M1, M3; MRDY pulses alternate, each 3 cycles apart.
- M1 read, MADDR1 = 32'h7000_0000 (select 7) → MRDY1 = MERR1 = 1 at t+1, MDATAR1 = 32'hDEAD_BEEF, no SWEN or SADDR change on any slave.
- RD_LAT = 4 build, M1 read of slave 1 → SADDR1 stable for 5 cycles, MRDY1 at t+6.
- RSTN pulled low during WAIT of an M3 read → MRDY3 never pulses, all outputs go to 0 asynchronously; after release, a simultaneous M1/M3 request grants M1 first.
